sos_multi_dist_calc: RTL and testbench

Multi-channel speed-of-sound ranging engine. It requests one impulse from the shared impulse generator, then runs windowed-energy onset detection independently on NUM_CH mic channels. Each channel's onset delay is confirmed over repeated rounds within a jitter tolerance, and the confirmed delay is reported per channel to downstream localisation logic. Runs on the audio-domain clock; sample cadence is given by the 24 kHz step_in strobe.

---
 rtl/sos_pkg.sv | 21 ++
 rtl/sos_energy_window.sv | 51 +++++
 rtl/sos_multi_dist_calc.sv | 173 +++++++++++++++++
 tb/tb_sos_multi_dist_calc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sos_pkg.sv
// Shared types and width helpers for the speed-of-sound ranging engine.
package sos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT_IMPULSE,
    ST_ANALYZE,
    ST_HOLDOFF,
    ST_DONE
  } sos_state_t;

  // Widths for the default configuration (8-bit samples, 16-sample windows, 8 rounds).
  localparam int ACC_W   = 12;
  localparam int ROUND_W = 4;

  function automatic int acc_width(input int sample_w, input int window_size);
    return sample_w + $clog2(window_size);
  endfunction

endpackage

// File: rtl/sos_energy_window.sv
// Per-channel windowed |sample| energy with a three-window history and onset test.
module sos_energy_window #(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 12
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                step_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                window_close_i,
  input  logic                start_i,
  output logic                onset_o
);

  localparam int TW = ACC_W + 1;

  logic [ACC_W-1:0] cur_q, prev_q, pprev_q;
  logic [ACC_W-1:0] sum_d;
  logic [TW-1:0]    thresh;

  // Magnitude is unsigned so the most negative code maps to +2^(SAMPLE_W-1).
  function automatic logic [SAMPLE_W-1:0] abs_mag(input logic signed [SAMPLE_W-1:0] s);
    return s[SAMPLE_W-1] ? SAMPLE_W'(-s) : SAMPLE_W'(s);
  endfunction

  assign sum_d   = cur_q + ACC_W'(abs_mag(sample_i));
  assign thresh  = {1'b0, pprev_q} + TW'(pprev_q >> 1);
  assign onset_o = step_i && window_close_i && (sum_d > prev_q) && ({1'b0, sum_d} > thresh);

  // History starts saturated so no onset fires until two real windows exist.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_q   <= '0;
      prev_q  <= '0;
      pprev_q <= '0;
    end else if (start_i) begin
      cur_q   <= '0;
      prev_q  <= '1;
      pprev_q <= '1;
    end else if (step_i) begin
      if (window_close_i) begin
        pprev_q <= prev_q;
        prev_q  <= sum_d;
        cur_q   <= '0;
      end else begin
        cur_q   <= sum_d;
      end
    end
  end

endmodule

// File: rtl/sos_multi_dist_calc.sv
// Multi-channel impulse ranging: fires impulses, detects per-channel onsets and confirms delays.
module sos_multi_dist_calc #(
  parameter int NUM_CH         = 2,
  parameter int SAMPLE_W       = 8,
  parameter int WINDOW_SIZE    = 16,
  parameter int MAX_DELAY      = 512,
  parameter int DELAY_W        = 12,
  parameter int CONFIRM_N      = 3,
  parameter int TOL            = 0,
  parameter int MAX_ROUNDS     = 8,
  parameter int HOLDOFF_CYCLES = 60_000_000
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       step_in,
  input  logic                       trigger_in,
  input  logic [NUM_CH*SAMPLE_W-1:0] mic_in,
  output logic                       impulse_req_out,
  input  logic                       impulse_done_in,
  output logic                       busy_out,
  output logic [NUM_CH*DELAY_W-1:0]  delay_out,
  output logic [NUM_CH-1:0]          delay_valid_out,
  output logic [NUM_CH-1:0]          fail_out
);
  import sos_pkg::*;

  localparam int AW    = acc_width(SAMPLE_W, WINDOW_SIZE);
  localparam int LOG_W = $clog2(WINDOW_SIZE);
  localparam int RW    = $clog2(MAX_ROUNDS + 1);
  localparam int CW    = $clog2(CONFIRM_N + 1);
  localparam int HW    = $clog2(HOLDOFF_CYCLES + 1);

  sos_state_t          state_q, state_d;
  logic [DELAY_W-1:0]  k_q, k_d, k_next;
  logic [RW-1:0]       round_q, round_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NUM_CH-1:0]   lock_q, lock_d, valid_q, valid_d, fail_q, fail_d, onset;
  logic [CW-1:0]       match_q [NUM_CH];
  logic [CW-1:0]       match_d [NUM_CH];
  logic [DELAY_W-1:0]  last_q  [NUM_CH];
  logic [DELAY_W-1:0]  last_d  [NUM_CH];
  logic [DELAY_W-1:0]  delay_q [NUM_CH];
  logic [DELAY_W-1:0]  delay_d [NUM_CH];
  logic                step_a, start, wclose;

  function automatic logic [DELAY_W-1:0] abs_diff(input logic [DELAY_W-1:0] a,
                                                  input logic [DELAY_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign step_a   = step_in && (state_q == ST_ANALYZE);
  assign start    = (state_q == ST_WAIT_IMPULSE) && impulse_done_in;
  assign k_next   = k_q + 1'b1;
  assign wclose   = (k_next[LOG_W-1:0] == '0);
  assign busy_out = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign delay_valid_out = valid_q;
  assign fail_out        = fail_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sos_energy_window #(.SAMPLE_W(SAMPLE_W), .ACC_W(AW)) u_win (
      .clk_i          (clk_in),
      .rst_n_i        (rst_n_in),
      .step_i         (step_a),
      .sample_i       (mic_in[c*SAMPLE_W +: SAMPLE_W]),
      .window_close_i (wclose),
      .start_i        (start),
      .onset_o        (onset[c])
    );
    assign delay_out[c*DELAY_W +: DELAY_W] = delay_q[c];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    round_d = round_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    valid_d = valid_q;
    fail_d  = fail_q;
    match_d = match_q;
    last_d  = last_q;
    delay_d = delay_q;
    impulse_req_out = 1'b0;
    unique case (state_q)
      ST_IDLE: if (trigger_in) begin
        valid_d = '0;
        fail_d  = '0;
        round_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          match_d[c] = '0;
          last_d[c]  = '0;
        end
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        impulse_req_out = 1'b1;
        state_d         = ST_WAIT_IMPULSE;
      end
      ST_WAIT_IMPULSE: if (impulse_done_in) begin
        k_d     = '0;
        lock_d  = '0;
        state_d = ST_ANALYZE;
      end
      ST_ANALYZE: if (step_in) begin
        k_d = k_next;
        for (int c = 0; c < NUM_CH; c++) begin
          if (!valid_q[c] && !lock_q[c] && onset[c]) begin
            lock_d[c] = 1'b1;
            if (match_q[c] == '0 || abs_diff(k_next, last_q[c]) > DELAY_W'(TOL))
              match_d[c] = CW'(1);
            else
              match_d[c] = match_q[c] + 1'b1;
            last_d[c] = k_next;
            if (match_d[c] == CW'(CONFIRM_N)) begin
              delay_d[c] = k_next;
              valid_d[c] = 1'b1;
            end
          end
        end
        // The MAX_DELAY window has already been evaluated above in this same cycle.
        if (&(lock_d | valid_q) || k_next == DELAY_W'(MAX_DELAY)) begin
          for (int c = 0; c < NUM_CH; c++)
            if (!lock_d[c] && !valid_q[c]) match_d[c] = '0;
          round_d = round_q + 1'b1;
          if (&valid_d) begin
            state_d = ST_DONE;
          end else if (round_d == RW'(MAX_ROUNDS)) begin
            fail_d  = ~valid_d;
            state_d = ST_DONE;
          end else begin
            hold_d  = '0;
            state_d = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == HW'(HOLDOFF_CYCLES - 1)) state_d = ST_FIRE;
        else                                   hold_d  = hold_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      round_q <= '0;
      hold_q  <= '0;
      lock_q  <= '0;
      valid_q <= '0;
      fail_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        match_q[c] <= '0;
        last_q[c]  <= '0;
        delay_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      round_q <= round_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
      match_q <= match_d;
      last_q  <= last_d;
      delay_q <= delay_d;
    end
  end

endmodule

// File: tb/tb_sos_multi_dist_calc.sv
// Directed bench: two engines (TOL=0 and TOL=16) sharing mic/step/impulse stimulus.
module tb_sos_multi_dist_calc;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_in;
  logic        trig_dut, trig_tol;
  logic [15:0] mic_in;
  logic        impulse_done_in;

  logic        req_dut, busy_dut, req_tol, busy_tol;
  logic [23:0] dly_dut, dly_tol;
  logic [1:0]  vld_dut, vld_tol, fail_dut, fail_tol;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;
  int tb_k = 0;
  int round_idx = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  sos_multi_dist_calc #(.TOL(0), .HOLDOFF_CYCLES(100)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .step_in(step_in), .trigger_in(trig_dut),
    .mic_in(mic_in), .impulse_req_out(req_dut), .impulse_done_in(impulse_done_in),
    .busy_out(busy_dut), .delay_out(dly_dut), .delay_valid_out(vld_dut), .fail_out(fail_dut)
  );

  sos_multi_dist_calc #(.TOL(16), .HOLDOFF_CYCLES(100)) u_tol (
    .clk_in(clk), .rst_n_in(rst_n), .step_in(step_in), .trigger_in(trig_tol),
    .mic_in(mic_in), .impulse_req_out(req_tol), .impulse_done_in(impulse_done_in),
    .busy_out(busy_tol), .delay_out(dly_tol), .delay_valid_out(vld_tol), .fail_out(fail_tol)
  );

  function automatic logic [7:0] sq(input int k);
    return (k % 2 == 1) ? 8'h40 : 8'hC0;
  endfunction

  // Sample for step number k (1-based within a round) on channel ch.
  function automatic logic [7:0] smp(input int ch, input int k);
    int on;
    case (mode)
      1: on = (ch == 0) ? 100 : 200;
      3: on = (ch == 0) ? (((round_idx % 2) == 1) ? 116 : 100) : 200;
      4: begin
        if (ch == 1) return 8'h00;
        on = 60;
      end
      5: begin
        if (ch == 0) return (k >= 97) ? 8'h80 : 8'h00;
        on = 200;
      end
      default: return 8'h00;
    endcase
    return (k >= on) ? sq(k) : 8'h00;
  endfunction

  // Impulse generator model and sample source.
  initial begin : env
    int phase;
    int done_cnt;
    phase = 0;
    done_cnt = 0;
    step_in = 1'b0;
    mic_in = '0;
    impulse_done_in = 1'b0;
    forever begin
      @(negedge clk);
      impulse_done_in = 1'b0;
      if (done_cnt != 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          impulse_done_in = 1'b1;
          tb_k = 0;
          round_idx++;
        end
      end else if (req_dut) begin
        done_cnt = 5;
        req_cnt++;
      end
      step_in = 1'b0;
      phase = (phase == 2) ? 0 : phase + 1;
      if (phase == 0 && !impulse_done_in) begin
        step_in = 1'b1;
        tb_k++;
        mic_in = {smp(1, tb_k), smp(0, tb_k)};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rk(input int rnd, input int kk, input string tag);
    int n = 0;
    while (!(round_idx == rnd && tb_k == kk) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_dut && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_run(input int m, input logic both);
    mode = m;
    round_idx = 0;
    req_cnt = 0;
    @(negedge clk);
    trig_dut = 1'b1;
    trig_tol = both;
    @(negedge clk);
    trig_dut = 1'b0;
    trig_tol = 1'b0;
  endtask

  initial begin : main
    rst_n = 1'b0;
    trig_dut = 1'b0;
    trig_tol = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_dut), 32'd0);
    check("rst_req", 32'(req_dut), 32'd0);
    check("rst_delay", 32'(dly_dut), 32'd0);
    check("rst_valid", 32'(vld_dut), 32'd0);
    check("rst_fail", 32'(fail_dut), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Square waves at k=100 / k=200, with a trigger pulse during the first holdoff.
    start_run(1, 1'b0);
    check("t1_busy_hi", 32'(busy_dut), 32'd1);
    wait_rk(1, 220, "t1_wait_holdoff");
    trig_dut = 1'b1;
    @(negedge clk);
    trig_dut = 1'b0;
    wait_idle("t1_idle");
    check("t1_delay_ch0", 32'(dly_dut[11:0]), 32'd112);
    check("t1_delay_ch1", 32'(dly_dut[23:12]), 32'd208);
    check("t1_valid", 32'(vld_dut), 32'd3);
    check("t1_fail", 32'(fail_dut), 32'd0);
    check("t1_req_cnt", 32'(req_cnt), 32'd3);

    // Silence on both channels: every round runs to k=512.
    start_run(2, 1'b0);
    wait_rk(8, 500, "t2_wait_r8");
    check("t2_busy_r8", 32'(busy_dut), 32'd1);
    wait_idle("t2_idle");
    check("t2_fail", 32'(fail_dut), 32'd3);
    check("t2_valid", 32'(vld_dut), 32'd0);
    check("t2_req_cnt", 32'(req_cnt), 32'd8);

    // Alternating ch0 onsets (128,112,128,...): TOL=16 confirms, TOL=0 does not.
    start_run(3, 1'b1);
    wait_idle("t3_idle");
    check("t3_tol_busy", 32'(busy_tol), 32'd0);
    check("t3_tol_valid", 32'(vld_tol), 32'd3);
    check("t3_tol_fail", 32'(fail_tol), 32'd0);
    check("t3_tol_ch0", 32'(dly_tol[11:0]), 32'd128);
    check("t3_tol_ch1", 32'(dly_tol[23:12]), 32'd208);
    check("t3_t0_valid", 32'(vld_dut), 32'd2);
    check("t3_t0_fail", 32'(fail_dut), 32'd1);
    check("t3_t0_ch1", 32'(dly_dut[23:12]), 32'd208);
    check("t3_req_cnt", 32'(req_cnt), 32'd8);

    // Ch0 onset at k=60, ch1 silent.
    start_run(4, 1'b0);
    wait_idle("t4_idle");
    check("t4_fail", 32'(fail_dut), 32'd2);
    check("t4_valid", 32'(vld_dut), 32'd1);
    check("t4_ch0", 32'(dly_dut[11:0]), 32'd64);
    check("t4_req_cnt", 32'(req_cnt), 32'd8);

    // Reset during analysis at k=40 clears everything at once.
    start_run(5, 1'b0);
    wait_rk(1, 40, "t5_wait_k40");
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy_dut), 32'd0);
    check("t5_rst_req", 32'(req_dut), 32'd0);
    check("t5_rst_delay", 32'(dly_dut), 32'd0);
    check("t5_rst_valid", 32'(vld_dut), 32'd0);
    check("t5_rst_fail", 32'(fail_dut), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_req", 32'(req_cnt), 32'd1);

    // Clean run; ch0 is full-scale -128 from k=97, so the 112 window sums to 2048.
    start_run(5, 1'b0);
    wait_idle("t5_idle");
    check("t5_ch0", 32'(dly_dut[11:0]), 32'd112);
    check("t5_ch1", 32'(dly_dut[23:12]), 32'd208);
    check("t5_valid", 32'(vld_dut), 32'd3);
    check("t5_fail", 32'(fail_dut), 32'd0);
    check("t5_req_cnt", 32'(req_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
